// File: rtl/prog_instruction_memory.sv
// Loadable instruction memory: serial program loader plus a registered, stallable fetch port.
// Optional load checksum enabled by defining IMEM_LOAD_CHECKSUM_EN.
module prog_instruction_memory #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 19,
  parameter int DEPTH       = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  input  logic                   stall,
  output logic                   fetch_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  input  logic                   load_start,
  input  logic [ADDR_WIDTH-1:0]  load_base,
  input  logic                   load_valid,
  input  logic                   load_last,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic                   load_ready,
  output logic                   load_done
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [INSTR_WIDTH-1:0] load_checksum
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic IDLE = 1'b0;
  localparam logic LOAD = 1'b1;
  localparam logic [PW-1:0]       LAST_PTR = PW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);

  logic                   state;
  logic [PW-1:0]          ptr;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic                   load_acc;
  logic                   fetch_acc;
  logic                   addr_ok;

  // A restart pulse takes priority over any word offered in the same cycle.
  assign load_ready  = (state == LOAD);
  assign load_acc    = (state == LOAD) && load_valid && !load_start;
  assign fetch_ready = (state == IDLE) && !stall && !load_start;
  assign fetch_acc   = fetch_req && fetch_ready;
  assign addr_ok     = {1'b0, fetch_addr} < DEPTH_X;

  // Storage has no reset so a program image survives a core reset.
  always_ff @(posedge clock) begin
    if (load_acc && !reset)
      mem[ptr] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= load_acc && load_last;
      if (load_start) begin
        state <= LOAD;
        ptr   <= load_base[PW-1:0];
      end else if (load_acc) begin
        ptr <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
        if (load_last)
          state <= IDLE;
      end
    end
  end

  // Out-of-range fetches return an all-zero NOP but still count as valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction <= '0;
      instr_valid <= 1'b0;
    end else if (load_start) begin
      instr_valid <= 1'b0;
    end else if (!stall) begin
      instr_valid <= fetch_acc;
      if (fetch_acc)
        instruction <= addr_ok ? mem[fetch_addr[PW-1:0]] : '0;
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset || load_start)
      load_checksum <= '0;
    else if (load_acc)
      load_checksum <= load_checksum ^ load_data;
  end
`endif

endmodule

// File: tb/tb_prog_instruction_memory.sv
// Directed bench for prog_instruction_memory (DEPTH=3000): vector table plus restart/reset sequences.
module tb_prog_instruction_memory;

  logic        clock;
  logic        reset;
  logic        fetch_req;
  logic [11:0] fetch_addr;
  logic        stall;
  logic        fetch_ready;
  logic [18:0] instruction;
  logic        instr_valid;
  logic        load_start;
  logic [11:0] load_base;
  logic        load_valid;
  logic        load_last;
  logic [18:0] load_data;
  logic        load_ready;
  logic        load_done;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [18:0] load_checksum;
`endif

  prog_instruction_memory #(.ADDR_WIDTH(12), .INSTR_WIDTH(19), .DEPTH(3000)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
    .fetch_ready(fetch_ready), .instruction(instruction), .instr_valid(instr_valid),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_last(load_last), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done)
`ifdef IMEM_LOAD_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string       name;
    logic        rst, ls;
    logic [11:0] base;
    logic        lv, ll;
    logic [18:0] ld;
    logic        fr;
    logic [11:0] fa;
    logic        st;
    logic        cr, efr, elr;
    logic        ci;
    logic [18:0] ei;
    logic        ev, ed, cc;
    logic [18:0] eck;
  } vec_t;

  vec_t tv[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(string name, logic rst, logic ls, logic [11:0] base,
                              logic lv, logic ll, logic [18:0] ld, logic fr,
                              logic [11:0] fa, logic st, logic cr, logic efr,
                              logic elr, logic ci, logic [18:0] ei, logic ev,
                              logic ed, logic cc, logic [18:0] eck);
    vec_t v;
    v.name = name; v.rst = rst; v.ls = ls; v.base = base; v.lv = lv; v.ll = ll;
    v.ld = ld; v.fr = fr; v.fa = fa; v.st = st; v.cr = cr; v.efr = efr;
    v.elr = elr; v.ci = ci; v.ei = ei; v.ev = ev; v.ed = ed; v.cc = cc; v.eck = eck;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic drv(logic ls, logic [11:0] base, logic lv, logic ll, logic [18:0] ld,
                     logic fr, logic [11:0] fa, logic st);
    load_start = ls; load_base = base; load_valid = lv; load_last = ll;
    load_data = ld; fetch_req = fr; fetch_addr = fa; stall = st;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_chk(string nm, logic [11:0] a, logic [18:0] exp);
    drv(0, 0, 0, 0, 0, 1, a, 0);
    tick();
    chk({nm, ".instr"}, 32'(instruction), 32'(exp));
    chk({nm, ".valid"}, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    //          name        rst ls base    lv ll ld        fr fa      st  cr efr elr ci ei        ev ed cc eck
    tv.push_back(mk("rst1",    1, 0, 12'h0,  0, 0, 19'h0,     0, 12'h0,  0,  0, 0, 0,  1, 19'h0,     0, 0, 0, 19'h0));
    tv.push_back(mk("rst2",    1, 0, 12'h0,  0, 0, 19'h0,     0, 12'h0,  0,  0, 0, 0,  1, 19'h0,     0, 0, 0, 19'h0));
    tv.push_back(mk("idle",    0, 0, 12'h0,  0, 0, 19'h0,     0, 12'h0,  0,  1, 1, 0,  1, 19'h0,     0, 0, 1, 19'h0));
    tv.push_back(mk("ld_start",0, 1, 12'h0,  0, 0, 19'h0,     0, 12'h0,  0,  1, 0, 0,  1, 19'h0,     0, 0, 0, 19'h0));
    tv.push_back(mk("ld_w0",   0, 0, 12'h0,  1, 0, 19'h12345, 0, 12'h0,  0,  1, 0, 1,  0, 19'h0,     0, 0, 0, 19'h0));
    tv.push_back(mk("ld_w1",   0, 0, 12'h0,  1, 0, 19'h00014, 0, 12'h0,  0,  1, 0, 1,  0, 19'h0,     0, 0, 0, 19'h0));
    tv.push_back(mk("ld_w2",   0, 0, 12'h0,  1, 1, 19'h7FFFF, 0, 12'h0,  0,  1, 0, 1,  0, 19'h0,     0, 1, 1, 19'h6DCAE));
    tv.push_back(mk("f0",      0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h0,  0,  1, 1, 0,  1, 19'h12345, 1, 0, 1, 19'h6DCAE));
    tv.push_back(mk("f1",      0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h1,  0,  1, 1, 0,  1, 19'h00014, 1, 0, 0, 19'h0));
    tv.push_back(mk("f2",      0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h2,  0,  1, 1, 0,  1, 19'h7FFFF, 1, 0, 0, 19'h0));
    tv.push_back(mk("f_idle",  0, 0, 12'h0,  0, 0, 19'h0,     0, 12'h0,  0,  1, 1, 0,  1, 19'h7FFFF, 0, 0, 1, 19'h6DCAE));
    tv.push_back(mk("wr_start",0, 1, 12'hBB7,0, 0, 19'h0,     0, 12'h0,  0,  1, 0, 0,  0, 19'h0,     0, 0, 0, 19'h0));
    tv.push_back(mk("wr_w0",   0, 0, 12'h0,  1, 0, 19'h0AAAA, 0, 12'h0,  0,  1, 0, 1,  0, 19'h0,     0, 0, 0, 19'h0));
    tv.push_back(mk("wr_w1",   0, 0, 12'h0,  1, 1, 19'h05555, 0, 12'h0,  0,  1, 0, 1,  0, 19'h0,     0, 1, 1, 19'h0FFFF));
    tv.push_back(mk("wr_fhi",  0, 0, 12'h0,  0, 0, 19'h0,     1, 12'hBB7,0,  1, 1, 0,  1, 19'h0AAAA, 1, 0, 0, 19'h0));
    tv.push_back(mk("wr_f0",   0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h0,  0,  1, 1, 0,  1, 19'h05555, 1, 0, 0, 19'h0));
    tv.push_back(mk("wr_f1",   0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h1,  0,  1, 1, 0,  1, 19'h00014, 1, 0, 0, 19'h0));
    tv.push_back(mk("oor_fff", 0, 0, 12'h0,  0, 0, 19'h0,     1, 12'hFFF,0,  1, 1, 0,  1, 19'h0,     1, 0, 0, 19'h0));
    tv.push_back(mk("oor_f2",  0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h2,  0,  1, 1, 0,  1, 19'h7FFFF, 1, 0, 0, 19'h0));
    tv.push_back(mk("oor_dep", 0, 0, 12'h0,  0, 0, 19'h0,     1, 12'hBB8,0,  1, 1, 0,  1, 19'h0,     1, 0, 0, 19'h0));
    tv.push_back(mk("st_f1",   0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h1,  0,  1, 1, 0,  1, 19'h00014, 1, 0, 0, 19'h0));
    tv.push_back(mk("stall1",  0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h2,  1,  1, 0, 0,  1, 19'h00014, 1, 0, 0, 19'h0));
    tv.push_back(mk("stall2",  0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h2,  1,  1, 0, 0,  1, 19'h00014, 1, 0, 0, 19'h0));
    tv.push_back(mk("stall3",  0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h2,  1,  1, 0, 0,  1, 19'h00014, 1, 0, 0, 19'h0));
    tv.push_back(mk("retry",   0, 0, 12'h0,  0, 0, 19'h0,     1, 12'h2,  0,  1, 1, 0,  1, 19'h7FFFF, 1, 0, 0, 19'h0));
    tv.push_back(mk("st_hold", 0, 0, 12'h0,  0, 0, 19'h0,     0, 12'h0,  1,  1, 0, 0,  1, 19'h7FFFF, 1, 0, 0, 19'h0));
    tv.push_back(mk("st_drop", 0, 0, 12'h0,  0, 0, 19'h0,     0, 12'h0,  0,  1, 1, 0,  1, 19'h7FFFF, 0, 0, 0, 19'h0));

    foreach (tv[i]) begin
      reset = tv[i].rst;
      drv(tv[i].ls, tv[i].base, tv[i].lv, tv[i].ll, tv[i].ld, tv[i].fr, tv[i].fa, tv[i].st);
      #1;
      if (tv[i].cr) begin
        chk({tv[i].name, ".fetch_ready"}, 32'(fetch_ready), 32'(tv[i].efr));
        chk({tv[i].name, ".load_ready"}, 32'(load_ready), 32'(tv[i].elr));
      end
      tick();
      if (tv[i].ci)
        chk({tv[i].name, ".instr"}, 32'(instruction), 32'(tv[i].ei));
      chk({tv[i].name, ".valid"}, 32'(instr_valid), 32'(tv[i].ev));
      chk({tv[i].name, ".done"}, 32'(load_done), 32'(tv[i].ed));
`ifdef IMEM_LOAD_CHECKSUM_EN
      if (tv[i].cc)
        chk({tv[i].name, ".checksum"}, 32'(load_checksum), 32'(tv[i].eck));
`endif
    end

    // Restart mid-load: 0x011 is preloaded so a leaked ignored word would show.
    drv(1, 12'h011, 0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 1, 1, 19'h0F0F0, 0, 0, 0); tick();
    chk("pre.done", 32'(load_done), 32'd1);
    drv(1, 12'h010, 0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 1, 0, 19'h11111, 0, 0, 0); tick();
    chk("rs_w0.done", 32'(load_done), 32'd0);
    drv(1, 12'h020, 1, 1, 19'h22222, 0, 0, 0); tick();
    chk("rs_restart.done", 32'(load_done), 32'd0);
    drv(0, 0, 1, 0, 19'h33333, 0, 0, 0); tick();
    chk("rs_w1.done", 32'(load_done), 32'd0);
    drv(0, 0, 1, 1, 19'h44444, 0, 0, 0); tick();
    chk("rs_w2.done", 32'(load_done), 32'd1);
`ifdef IMEM_LOAD_CHECKSUM_EN
    chk("rs.checksum", 32'(load_checksum), 32'h77777);
`endif
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("rs_after.done", 32'(load_done), 32'd0);
    fetch_chk("rs_f010", 12'h010, 19'h11111);
    fetch_chk("rs_f011", 12'h011, 19'h0F0F0);
    fetch_chk("rs_f020", 12'h020, 19'h33333);
    fetch_chk("rs_f021", 12'h021, 19'h44444);

    // Reset during a load: state back to IDLE, written words survive, no done.
    drv(1, 12'h030, 0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 1, 0, 19'h55555, 0, 0, 0); tick();
    drv(0, 0, 1, 0, 19'h66666, 0, 0, 0); tick();
    reset = 1'b1;
    drv(0, 0, 1, 1, 19'h77777, 0, 0, 0); tick();
    chk("mr.done", 32'(load_done), 32'd0);
    chk("mr.valid", 32'(instr_valid), 32'd0);
    chk("mr.instr", 32'(instruction), 32'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    chk("mr.checksum", 32'(load_checksum), 32'd0);
`endif
    reset = 1'b0;
    drv(0, 0, 1, 1, 19'h12121, 0, 0, 0);
    #1;
    chk("mr_idle.fetch_ready", 32'(fetch_ready), 32'd1);
    chk("mr_idle.load_ready", 32'(load_ready), 32'd0);
    tick();
    chk("mr_idle.done", 32'(load_done), 32'd0);
    fetch_chk("mr_f030", 12'h030, 19'h55555);
    fetch_chk("mr_f031", 12'h031, 19'h66666);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
